sirv_gnrl_skid_buf: RTL



---
 rtl/sirv_gnrl_skid_buf.sv | 100 ++++++++++
 1 files changed

// File: rtl/sirv_gnrl_skid_buf.sv
// Two-entry valid/ready skid buffer with registered ready/valid and data paths.
// Also provides chk_dat, a handshake-qualified copy of i_dat for a downstream X checker.
module sirv_gnrl_skid_buf #(
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_vld,
  output logic          i_rdy,
  input  logic [DW-1:0] i_dat,
  output logic          o_vld,
  input  logic          o_rdy,
  output logic [DW-1:0] o_dat,
  output logic [DW-1:0] chk_dat,
  output logic [1:0]    o_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [DW-1:0] mreg;
  logic [DW-1:0] sreg;
  logic [DW-1:0] mreg_d;
  logic          mreg_ld;
  logic          mreg_from_s;
  logic          sreg_ld;
  logic          rdy_q;
  logic          vld_q;
  logic          in_hs;
  logic          out_hs;

  assign in_hs  = i_vld & rdy_q;
  assign out_hs = vld_q & o_rdy;

  // State register plus registered handshake outputs and payload storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
      rdy_q <= 1'b1;
      vld_q <= 1'b0;
      mreg  <= '0;
      sreg  <= '0;
    end else begin
      state <= state_nxt;
      rdy_q <= (state_nxt != TWO);
      vld_q <= (state_nxt != EMPTY);
      if (mreg_ld) mreg <= mreg_d;
      if (sreg_ld) sreg <= i_dat;
    end
  end

  // Next-state and register-load decode; illegal code 3 falls back to EMPTY
  always_comb begin
    state_nxt   = state;
    mreg_ld     = 1'b0;
    mreg_from_s = 1'b0;
    sreg_ld     = 1'b0;
    case (state)
      EMPTY: begin
        if (in_hs) begin
          state_nxt = ONE;
          mreg_ld   = 1'b1;
        end
      end
      ONE: begin
        case ({in_hs, out_hs})
          2'b11: mreg_ld = 1'b1;
          2'b10: begin
            state_nxt = TWO;
            sreg_ld   = 1'b1;
          end
          2'b01: state_nxt = EMPTY;
          default: ;
        endcase
      end
      TWO: begin
        if (out_hs) begin
          state_nxt   = ONE;
          mreg_ld     = 1'b1;
          mreg_from_s = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  assign mreg_d  = mreg_from_s ? sreg : i_dat;

  assign i_rdy   = rdy_q;
  assign o_vld   = vld_q;
  assign o_dat   = mreg;
  assign o_cnt   = 2'(state);
  assign chk_dat = in_hs ? i_dat : {DW{1'b0}};

endmodule
